// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
//   Shared encodings for the data memory responder:
//     - access size codes carried on req_size
//     - FSM state encoding, also visible on the responder's dbg_state output
// ----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage : dmem_pkg

// File: rtl/dmem_lane_align.sv
// ----------------------------------------------------------------------------
// dmem_lane_align
//   Purely combinational lane handling for byte/half/word accesses.
//   Store side: byte enables from size and addr[1:0], plus the store data
//   replicated into every lane so the enabled lanes pick up the right bits.
//   Load side: selects the addressed byte/half out of the array word and
//   sign- or zero-extends it to 32 bits.
// Ports
//   size_i      access size code (dmem_pkg SZ_*)
//   addr_lo_i   byte offset within the word
//   wdata_i     right-aligned store data
//   unsigned_i  1 = zero-extend loads, 0 = sign-extend (ignored for words)
//   rword_i     word read from the array
//   be_o        byte enables for the store (all zero for illegal size)
//   wdata_o     store data replicated across lanes
//   rdata_o     extracted and extended load data
// ----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic        unsigned_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o     = 4'b0000;
        wdata_o  = 32'h0;
        rdata_o  = 32'h0;
        byte_sel = 8'h0;
        half_sel = 16'h0;
        case (size_i)
            SZ_BYTE: begin
                be_o     = 4'b0001 << addr_lo_i;
                wdata_o  = {4{wdata_i[7:0]}};
                byte_sel = rword_i[8*addr_lo_i +: 8];
                rdata_o  = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
            end
            SZ_HALF: begin
                // Alignment is checked upstream, so only addr[1] picks the half.
                be_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o  = {2{wdata_i[15:0]}};
                half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
                rdata_o  = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rword_i;
            end
            default: begin
                be_o = 4'b0000;
            end
        endcase
    end

endmodule : dmem_lane_align

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the core's load/store port. One request at a
//   time is accepted, the word array is accessed READ_LATENCY cycles after
//   the accept edge, and the result is returned on a response channel.
//
// Handshake rules (both channels): a transfer happens on a rising edge where
//   valid && ready are both high. The sender holds valid and payload stable
//   until that edge; ready never depends combinationally on valid.
//   req_ready is high only in IDLE; requests offered while busy are ignored.
//   rsp_valid/rsp_rdata/rsp_err stay stable until the response handshake.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   req_valid/ready    request handshake
//   req_we             1 = store, 0 = load
//   req_addr           byte address
//   req_wdata          right-aligned store data
//   req_size           00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned       zero-extend sub-word loads when 1
//   rsp_valid/ready    response handshake
//   rsp_rdata          extended load data; 0 for stores and errors
//   rsp_err            misaligned, out-of-range or illegal-size request
//   dbg_state          current FSM state (dmem_pkg::state_e encoding)
// ----------------------------------------------------------------------------
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [31:0] BASE_ADDR    = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(READ_LATENCY + 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [1:0]         size_q;
    logic               unsigned_q;
    logic               rsp_valid_q;
    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;

    logic [31:0]        mem_q [DEPTH_WORDS];

    // Decode of the latched request.
    logic [31:0]        off_d;
    logic [AW-1:0]      word_idx_d;
    logic               err_d;
    logic               access_d;
    logic               commit_d;
    logic [3:0]         be_d;
    logic [31:0]        wrep_d;
    logic [31:0]        load_d;

    // Unsigned subtraction: addresses below BASE_ADDR wrap to huge offsets
    // and fall into the range error, so the index never wraps.
    assign off_d      = addr_q - BASE_ADDR;
    assign word_idx_d = off_d[AW+1:2];

    always_comb begin
        err_d = 1'b0;
        if (size_q == SZ_ILLEGAL)                         err_d = 1'b1;
        if (size_q == SZ_HALF && addr_q[0] != 1'b0)       err_d = 1'b1;
        if (size_q == SZ_WORD && addr_q[1:0] != 2'b00)    err_d = 1'b1;
        if (off_d >= (32'(DEPTH_WORDS) << 2))             err_d = 1'b1;
    end

    // The access edge is the WAIT cycle whose counter has run down to 0.
    assign access_d = (state_q == ST_WAIT) && (cnt_q == '0);
    assign commit_d = access_d && we_q && !err_d;

    dmem_lane_align u_align (
        .size_i     (size_q),
        .addr_lo_i  (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .unsigned_i (unsigned_q),
        .rword_i    (mem_q[word_idx_d]),
        .be_o       (be_d),
        .wdata_o    (wrep_d),
        .rdata_o    (load_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            size_q      <= SZ_BYTE;
            unsigned_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        cnt_q      <= CNT_W'(READ_LATENCY - 1);
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_d;
                        rsp_rdata_q <= (err_d || we_q) ? 32'h0 : load_d;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Array is never cleared; reset only blocks a pending store.
    always_ff @(posedge clk) begin
        if (!reset && commit_d) begin
            for (int b = 0; b < 4; b++) begin
                if (be_d[b]) begin
                    mem_q[word_idx_d][8*b +: 8] <= wrep_d[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state_q;

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int n_total = 0;
  int n_bad = 0;

  data_mem_responder #(
    .DEPTH_WORDS  (1024),
    .READ_LATENCY (2),
    .BASE_ADDR    (32'h0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drives one request and takes its response. Called at posedge+1.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("req_ready_before_accept", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rdata = rsp_rdata;
    err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", {31'h0, rsp_valid}, 32'h0);
    chk("req_ready_after_hs", {31'h0, req_ready}, 32'h1);
  endtask

  function automatic void add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic uns,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] held;

    //          we    addr          wdata         sz uns  exp_rdata     err
    add(1'b1, 32'h10,       32'hDEADBEEF, W, 0, 32'h00000000, 0);
    add(1'b0, 32'h10,       32'h0,        W, 0, 32'hDEADBEEF, 0);
    add(1'b1, 32'h20,       32'h11223344, W, 0, 32'h00000000, 0);
    add(1'b1, 32'h21,       32'hABCDEF80, B, 0, 32'h00000000, 0);
    add(1'b0, 32'h21,       32'h0,        B, 0, 32'hFFFFFF80, 0);
    add(1'b0, 32'h21,       32'h0,        B, 1, 32'h00000080, 0);
    add(1'b0, 32'h20,       32'h0,        W, 0, 32'h11228044, 0);
    add(1'b0, 32'h23,       32'h0,        B, 0, 32'h00000011, 0);
    add(1'b1, 32'h30,       32'hAABBCCDD, W, 0, 32'h00000000, 0);
    add(1'b1, 32'h32,       32'h55551234, H, 0, 32'h00000000, 0);
    add(1'b0, 32'h32,       32'h0,        H, 1, 32'h00001234, 0);
    add(1'b0, 32'h30,       32'h0,        H, 0, 32'hFFFFCCDD, 0);
    add(1'b0, 32'h30,       32'h0,        H, 1, 32'h0000CCDD, 0);
    add(1'b0, 32'h30,       32'h0,        W, 0, 32'h1234CCDD, 0);
    add(1'b0, 32'h33,       32'h0,        B, 1, 32'h00000012, 0);
    add(1'b1, 32'h0,        32'h01020304, W, 0, 32'h00000000, 0);
    add(1'b1, 32'hFFC,      32'h5A5A5A5A, W, 0, 32'h00000000, 0);
    add(1'b0, 32'hFFC,      32'h0,        W, 0, 32'h5A5A5A5A, 0);
    add(1'b0, 32'h2,        32'h0,        W, 0, 32'h00000000, 1);
    add(1'b1, 32'h1,        32'h0000FFFF, H, 0, 32'h00000000, 1);
    add(1'b0, 32'h0,        32'h0,        X, 0, 32'h00000000, 1);
    add(1'b1, 32'h0,        32'hFFFFFFFF, X, 0, 32'h00000000, 1);
    add(1'b1, 32'h1000,     32'hFFFFFFFF, W, 0, 32'h00000000, 1);
    add(1'b0, 32'h1000,     32'h0,        W, 0, 32'h00000000, 1);
    add(1'b0, 32'hFFFFFFFC, 32'h0,        W, 0, 32'h00000000, 1);
    add(1'b0, 32'h0,        32'h0,        W, 0, 32'h01020304, 0);
    add(1'b0, 32'h0,        32'h0,        B, 1, 32'h00000004, 0);
    add(1'b0, 32'h10,       32'h0,        W, 1, 32'hDEADBEEF, 0);

    // reset values
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err",   {31'h0, rsp_err}, 32'h0);
    chk("reset_state",     {30'h0, dbg_state}, 32'h0);

    // table-driven vectors
    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      chk($sformatf("vec%0d_latency", i), lat, 32'd2);
    end

    // backpressure: response held 5 cycles, a new request offered meanwhile
    req_we = 1'b0; req_addr = 32'h10; req_size = W; req_unsigned = 1'b0; req_wdata = 32'h0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("bp_latency", lat, 32'd2);
    held = rsp_rdata;
    chk("bp_rdata", held, 32'hDEADBEEF);
    req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_size = W;
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid_c%0d", c), {31'h0, rsp_valid}, 32'h1);
      chk($sformatf("bp_rdata_c%0d", c), rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp_err_c%0d", c), {31'h0, rsp_err}, 32'h0);
      chk($sformatf("bp_req_ready_c%0d", c), {31'h0, req_ready}, 32'h0);
      chk($sformatf("bp_state_c%0d", c), {30'h0, dbg_state}, 32'h2);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("bp_hs_valid", {31'h0, rsp_valid}, 32'h0);
    chk("bp_hs_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    chk("bp_no_accept", {30'h0, dbg_state}, 32'h0);
    do_req(1'b0, 32'h10, 32'h0, W, 1'b0, rd, er, lat);
    chk("bp_ignored_store", rd, 32'hDEADBEEF);

    // reset one cycle after a store accept: store must not commit
    do_req(1'b1, 32'h40, 32'h13579BDF, W, 1'b0, rd, er, lat);
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D; req_size = W;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("mid_rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid_rst_idle_valid", {31'h0, rsp_valid}, 32'h0);
    end
    do_req(1'b0, 32'h40, 32'h0, W, 1'b0, rd, er, lat);
    chk("mid_rst_word_kept", rd, 32'h13579BDF);
    chk("mid_rst_err", {31'h0, er}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_data_mem_responder
